// File: rtl/relay_pulse_sequencer.sv
// Queues per-channel latching-relay direction requests and round-robins them onto the coil drivers, one coil at a time.
// Coil drive starts 2 cycles after an accepted request when idle; req_ready is always high outside reset, and repeat requests overwrite the queued direction.
module relay_pulse_sequencer #(
  parameter int NUM_RELAYS      = 4,
  parameter int PULSE_CYCLES    = 2500000,
  parameter int DEADTIME_CYCLES = 250000,
  parameter int CNT_WIDTH       = 22,
  // One extra index bit so out-of-range channel numbers can be presented and dropped
  parameter int CH_W            = $clog2(NUM_RELAYS) + 1
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CH_W-1:0]       req_channel,
  input  logic                  req_dir,
  output logic [NUM_RELAYS-1:0] relay_a,
  output logic [NUM_RELAYS-1:0] relay_b,
  output logic [NUM_RELAYS-1:0] relay_state,
  output logic [NUM_RELAYS-1:0] relay_known,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(NUM_RELAYS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  timer_q, timer_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      cur_ch_q, cur_ch_d;
  logic                  cur_dir_q, cur_dir_d;
  logic [NUM_RELAYS-1:0] pending_q, pending_d;
  logic [NUM_RELAYS-1:0] pend_dir_q, pend_dir_d;
  logic [NUM_RELAYS-1:0] relay_a_q, relay_a_d;
  logic [NUM_RELAYS-1:0] relay_b_q, relay_b_d;
  logic [NUM_RELAYS-1:0] relay_state_q, relay_state_d;
  logic [NUM_RELAYS-1:0] relay_known_q, relay_known_d;
  logic                  done_q, done_d;
  logic                  req_ready_q, req_ready_d;

  logic                  acc_vld;
  logic [PTR_W-1:0]      acc_ch;
  logic                  win_vld;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      scan_idx;
  logic                  win_skip;
  logic                  pulse_end;
  logic                  skip_done;

  assign acc_vld = req_valid && req_ready_q && (int'(req_channel) < NUM_RELAYS);
  assign acc_ch  = req_channel[PTR_W-1:0];

  // Rotating priority scan starting at rr_ptr; only the registered pending vector takes part.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_RELAYS; i++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_RELAYS);
      if (!win_vld && pending_q[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign win_skip = relay_known_q[win_idx] && (relay_state_q[win_idx] == pend_dir_q[win_idx]);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      rr_ptr_q      <= '0;
      cur_ch_q      <= '0;
      cur_dir_q     <= 1'b0;
      pending_q     <= '0;
      pend_dir_q    <= '0;
      relay_a_q     <= '0;
      relay_b_q     <= '0;
      relay_state_q <= '0;
      relay_known_q <= '0;
      done_q        <= 1'b0;
      req_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_ch_q      <= cur_ch_d;
      cur_dir_q     <= cur_dir_d;
      pending_q     <= pending_d;
      pend_dir_q    <= pend_dir_d;
      relay_a_q     <= relay_a_d;
      relay_b_q     <= relay_b_d;
      relay_state_q <= relay_state_d;
      relay_known_q <= relay_known_d;
      done_q        <= done_d;
      req_ready_q   <= req_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rr_ptr_d   = rr_ptr_q;
    cur_ch_d   = cur_ch_q;
    cur_dir_d  = cur_dir_q;
    pending_d  = pending_q;
    pend_dir_d = pend_dir_q;
    pulse_end  = 1'b0;
    skip_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          pending_d[win_idx] = 1'b0;
          rr_ptr_d           = PTR_W'((int'(win_idx) + 1) % NUM_RELAYS);
          if (win_skip) begin
            skip_done = 1'b1;
          end else begin
            cur_ch_d  = win_idx;
            cur_dir_d = pend_dir_q[win_idx];
            timer_d   = CNT_WIDTH'(PULSE_CYCLES - 1);
            state_d   = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        if (timer_q == '0) begin
          pulse_end = 1'b1;
          timer_d   = CNT_WIDTH'(DEADTIME_CYCLES - 1);
          state_d   = S_DEAD;
        end else begin
          timer_d = timer_q - CNT_WIDTH'(1);
        end
      end
      S_DEAD: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Applied after the winner clear so a same-cycle request to the winning channel stays queued.
    if (acc_vld) begin
      pending_d[acc_ch]  = 1'b1;
      pend_dir_d[acc_ch] = req_dir;
    end
  end

  always_comb begin
    relay_a_d     = '0;
    relay_b_d     = '0;
    relay_state_d = relay_state_q;
    relay_known_d = relay_known_q;
    req_ready_d   = 1'b1;
    done_d        = pulse_end || skip_done;
    if (state_d == S_PULSE) begin
      relay_a_d[cur_ch_d] = cur_dir_d;
      relay_b_d[cur_ch_d] = !cur_dir_d;
    end
    if (pulse_end) begin
      relay_state_d[cur_ch_q] = cur_dir_q;
      relay_known_d[cur_ch_q] = 1'b1;
    end
  end

  assign req_ready   = req_ready_q;
  assign relay_a     = relay_a_q;
  assign relay_b     = relay_b_q;
  assign relay_state = relay_state_q;
  assign relay_known = relay_known_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE) || (|pending_q);

endmodule

// File: tb/tb_relay_pulse_sequencer.sv
// Bench for relay_pulse_sequencer: timeline model of pulses/deadtimes compared every cycle, plus directed literal checks.
module tb_relay_pulse_sequencer;

  localparam int NUM   = 4;
  localparam int PULSE = 10;
  localparam int DEAD  = 4;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_channel;
  logic           req_dir;
  logic [NUM-1:0] relay_a;
  logic [NUM-1:0] relay_b;
  logic [NUM-1:0] relay_state;
  logic [NUM-1:0] relay_known;
  logic           busy;
  logic           done;

  relay_pulse_sequencer #(
    .NUM_RELAYS      (NUM),
    .PULSE_CYCLES    (PULSE),
    .DEADTIME_CYCLES (DEAD),
    .CNT_WIDTH       (8),
    .CH_W            (3)
  ) dut (
    .sys_clk     (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_channel (req_channel),
    .req_dir     (req_dir),
    .relay_a     (relay_a),
    .relay_b     (relay_b),
    .relay_state (relay_state),
    .relay_known (relay_known),
    .busy        (busy),
    .done        (done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: queued requests plus a timeline of the single active pulse.
  bit m_valid = 0;
  bit m_ready = 0;
  bit m_pend  [NUM];
  bit m_pdir  [NUM];
  bit m_state [NUM];
  bit m_known [NUM];
  int m_rr = 0;
  bit m_act = 0;
  int m_act_ch = 0;
  bit m_act_dir = 0;
  int m_act_start = 0;
  int m_act_end = 0;
  int m_idle_from = 0;
  int m_done_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < NUM; i++) r |= m_pend[i];
    return r;
  endfunction

  initial begin
    int w;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1;
        m_ready = 0;
        for (int i = 0; i < NUM; i++) begin
          m_pend[i] = 0; m_pdir[i] = 0; m_state[i] = 0; m_known[i] = 0;
        end
        m_rr = 0;
        m_act = 0;
        m_idle_from = cyc + 1;
        m_done_q.delete();
      end else begin
        if (m_act && cyc == m_act_end) begin
          m_state[m_act_ch] = m_act_dir;
          m_known[m_act_ch] = 1;
          m_act = 0;
        end
        if (cyc >= m_idle_from && any_pend()) begin
          w = -1;
          for (int k = 0; k < NUM; k++)
            if (w < 0 && m_pend[(m_rr + k) % NUM]) w = (m_rr + k) % NUM;
          m_pend[w] = 0;
          m_rr = (w + 1) % NUM;
          if (m_known[w] && m_state[w] == m_pdir[w]) begin
            m_done_q.push_back(cyc + 1);
          end else begin
            m_act       = 1;
            m_act_ch    = w;
            m_act_dir   = m_pdir[w];
            m_act_start = cyc + 1;
            m_act_end   = cyc + PULSE;
            m_done_q.push_back(cyc + PULSE + 1);
            m_idle_from = cyc + 1 + PULSE + DEAD;
          end
        end
        if (req_valid && m_ready && req_channel < NUM) begin
          m_pend[req_channel] = 1;
          m_pdir[req_channel] = req_dir;
        end
        m_ready = 1;
      end
      cyc++;
      while (m_done_q.size() > 0 && m_done_q[0] < cyc) void'(m_done_q.pop_front());
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [NUM-1:0] ea, eb, es, ek;
    logic           ebusy, edone, inv_ok;
    logic [19:0]    act_v, exp_v;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        ea = '0; eb = '0; es = '0; ek = '0;
        ebusy = any_pend() || (cyc < m_idle_from);
        for (int i = 0; i < NUM; i++) begin
          es[i] = m_state[i];
          ek[i] = m_known[i];
        end
        if (m_act && cyc >= m_act_start && cyc <= m_act_end) begin
          ea[m_act_ch] = m_act_dir;
          eb[m_act_ch] = !m_act_dir;
        end
        edone  = (m_done_q.size() > 0 && m_done_q[0] == cyc);
        inv_ok = ((relay_a & relay_b) == '0) && ($countones(relay_a | relay_b) <= 1);
        act_v  = {req_ready, busy, done, relay_a, relay_b, relay_state, relay_known, inv_ok};
        exp_v  = {m_ready, ebusy, edone, ea, eb, es, ek, 1'b1};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL model cyc=%0d: got rdy/busy/done/a/b/st/kn/inv=%b required %b", cyc, act_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic send(input int ch, input bit dir);
    req_valid   = 1'b1;
    req_channel = 3'(ch);
    req_dir     = dir;
    @(posedge clk); #1;
    req_valid   = 1'b0;
  endtask

  task automatic at_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, ta, tc, td, te;
    rst = 1'b1; req_valid = 1'b0; req_channel = '0; req_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {req_ready, busy, done, relay_a, relay_b, relay_state, relay_known}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", req_ready, 1);

    // Single pulse on ch2, output mode
    t0 = cyc;
    send(2, 1);
    at_cyc(t0 + 1);  chk("t1_before_drive", relay_a, 4'b0000);
    chk("t1_busy_pending", busy, 1);
    at_cyc(t0 + 2);  chk("t1_first_drive", relay_a, 4'b0100);
    chk("t1_b_off", relay_b, 4'b0000);
    at_cyc(t0 + 11); chk("t1_last_drive", relay_a, 4'b0100);
    at_cyc(t0 + 12); chk("t1_done", done, 1);
    chk("t1_coil_off", relay_a, 4'b0000);
    chk("t1_state_known", {relay_state, relay_known}, 8'b0100_0100);
    at_cyc(t0 + 15); chk("t1_busy_dead", busy, 1);
    at_cyc(t0 + 16); chk("t1_busy_drop", busy, 0);

    // Same request again: skip
    t1 = cyc;
    send(2, 1);
    at_cyc(t1 + 1);  chk("t2_no_done_yet", done, 0);
    at_cyc(t1 + 2);  chk("t2_skip_done", done, 1);
    chk("t2_no_drive", relay_a | relay_b, 0);
    at_cyc(t1 + 3);  chk("t2_idle", busy, 0);

    // ch0 pulse sets rr_ptr to 1, burst of ch3/ch0/ch1 during it
    ta = cyc;
    send(0, 0);
    at_cyc(ta + 3); send(3, 1);
    send(0, 1);
    send(1, 1);
    at_cyc(ta + 6);  chk("t3_ch0_drive_b", relay_b, 4'b0001);
    at_cyc(ta + 17); chk("t3_first_ch1", relay_a, 4'b0010);
    at_cyc(ta + 32); chk("t3_second_ch3", relay_a, 4'b1000);
    at_cyc(ta + 47); chk("t3_third_ch0", relay_a, 4'b0001);
    at_cyc(ta + 60); chk("t3_busy_last_dead", busy, 1);
    at_cyc(ta + 61); chk("t3_idle", busy, 0);

    // Latest direction wins while ch1 is pending behind a ch2 pulse
    tc = cyc;
    send(2, 0);
    at_cyc(tc + 3); send(1, 1);
    send(1, 0);
    at_cyc(tc + 17); chk("t4_ch1_b_drive", relay_b, 4'b0010);
    chk("t4_ch1_a_off", relay_a, 4'b0000);
    at_cyc(tc + 27); chk("t4_states", relay_state, 4'b1001);
    chk("t4_known", relay_known, 4'b1111);
    at_cyc(tc + 31); chk("t4_idle", busy, 0);

    // Reset in the middle of a pulse
    td = cyc;
    send(3, 0);
    at_cyc(td + 3); send(0, 0);
    at_cyc(td + 6); chk("t5_mid_pulse", relay_b, 4'b1000);
    rst = 1'b1;
    at_cyc(td + 7); chk("t5_coils_off", relay_a | relay_b, 0);
    chk("t5_known_clr", relay_known, 0);
    chk("t5_pending_clr", busy, 0);
    chk("t5_ready_low", req_ready, 0);
    at_cyc(td + 8); chk("t5_ready_still_low", req_ready, 0);
    rst = 1'b0;
    at_cyc(td + 9); chk("t5_ready_back", req_ready, 1);
    chk("t5_state_clr", relay_state, 0);

    // Out-of-range channel: accepted and dropped
    te = cyc;
    send(5, 1);
    at_cyc(te + 1); chk("t6_no_pending", busy, 0);
    at_cyc(te + 2); chk("t6_no_done", done, 0);
    chk("t6_no_drive", relay_a | relay_b, 0);
    at_cyc(te + 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
